// File: rtl/window_pkg.sv
// ---------------------------------------------------------------------------
// window_pkg
// Shared types and helpers for the 3x3 sliding-window generator.
//   K          : window edge length (3)
//   DATA_WIDTH : bits per pixel
//   pixel_t    : one pixel
//   column_t   : K vertically aligned pixels, index 0 = oldest row (r-2)
//   window_t   : K rows of K pixels, element (i,j) = w[i][j]
//   pack_window / unpack_window convert between window_t and the flat
//   output bus, where element (i,j) lives at [(K*i+j)*DATA_WIDTH +: DATA_WIDTH].
// ---------------------------------------------------------------------------
package window_pkg;

  localparam int K          = 3;
  localparam int DATA_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0] pixel_t;
  typedef pixel_t  column_t [K];
  typedef column_t window_t [K];

  function automatic logic [K*K*DATA_WIDTH-1:0] pack_window(input window_t w);
    logic [K*K*DATA_WIDTH-1:0] flat;
    flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        flat[(K*i+j)*DATA_WIDTH +: DATA_WIDTH] = w[i][j];
      end
    end
    return flat;
  endfunction

  function automatic void unpack_window(input logic [K*K*DATA_WIDTH-1:0] flat,
                                        output window_t w);
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        w[i][j] = flat[(K*i+j)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  endfunction

endpackage

// File: rtl/window_col_shift.sv
// ---------------------------------------------------------------------------
// window_col_shift
// K-deep shift register of pixel columns. Slot 0 is the oldest column
// (c-2), slot K-1 the newest (c). On en the columns move one slot toward
// slot 0 and col_in enters slot K-1.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset, clears every slot
//   en      in   shift enable
//   col_in  in   incoming column
//   col_q   out  registered columns
//   col_d   out  post-shift view (what col_q becomes if en is high);
//                lets the parent register a window in the same cycle
//                the column is accepted
// ---------------------------------------------------------------------------
module window_col_shift
  import window_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  column_t col_in,
  output column_t col_q [K],
  output column_t col_d [K]
);

  always_comb begin
    for (int j = 0; j < K-1; j++) begin
      col_d[j] = col_q[j+1];
    end
    col_d[K-1] = col_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < K; j++) begin
        for (int i = 0; i < K; i++) begin
          col_q[j][i] <= '0;
        end
      end
    end else if (en) begin
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/window_3x3_gen.sv
// ---------------------------------------------------------------------------
// window_3x3_gen
// Sliding 3x3 window generator fed by the line-buffer chain. Each accepted
// beat carries one column of three vertically aligned taps; the block keeps
// the last three columns and emits a 3x3 window per valid image position.
//
// Optional build macro: WINDOW_GEN_PAD_EN
//   defined   : causal zero padding, one window per accepted pixel;
//               elements above row 0 or left of col 0 are forced to 0
//   undefined : only windows fully inside the image (r>=2, c>=2)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   tap_in     in   [0+:DW]=row r, [DW+:DW]=row r-1, [2DW+:DW]=row r-2
//   tap_valid  in   tap_in valid
//   tap_ready  out  tap_in accepted this cycle when tap_valid is high
//   win_out    out  element (i,j) at [(3i+j)*DW +: DW]; i=0 row r-2, j=0 col c-2
//   win_valid  out  win_out valid
//   win_ready  in   consumer takes win_out
//   win_last   out  last window of the frame (qualified by win_valid)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a source holding valid keeps its payload stable until ready.
// Pixel width comes from window_pkg::DATA_WIDTH.
// ---------------------------------------------------------------------------
module window_3x3_gen
  import window_pkg::*;
#(
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [K*DATA_WIDTH-1:0]   tap_in,
  input  logic                      tap_valid,
  output logic                      tap_ready,
  output logic [K*K*DATA_WIDTH-1:0] win_out,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic                      win_last
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          col_wrap;
  logic          row_wrap;
  logic          emit;

  column_t       col_in;
  column_t       col_q [K];
  column_t       col_d [K];
  window_t       win_d;

  // One output register stage: a new tap may enter whenever the output
  // slot is empty or is being drained this cycle.
  assign tap_ready = rst & (~win_valid | win_ready);
  assign accept    = tap_valid & tap_ready;
  assign col_wrap  = (col == COL_LAST);
  assign row_wrap  = (row == ROW_LAST);

  // Raster position of the pixel currently presented on tap_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        row <= row_wrap ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Column slot index 0 is the oldest row (r-2), which sits in the top tap.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      col_in[i] = tap_in[(K-1-i)*DW +: DW];
    end
  end

  window_col_shift u_col_shift (
    .clk    (clk),
    .rst_n  (rst),
    .en     (accept),
    .col_in (col_in),
    .col_q  (col_q),
    .col_d  (col_d)
  );

  // Transpose the post-shift columns into row-major window order.
  // At the start of a row the older columns hold stale pixels from the
  // previous row; they are either suppressed (emit) or zeroed (padding).
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win_d[i][j] = col_d[j][i];
`ifdef WINDOW_GEN_PAD_EN
        if ((i + int'(row) < K-1) || (j + int'(col) < K-1)) begin
          win_d[i][j] = '0;
        end
`endif
      end
    end
  end

`ifdef WINDOW_GEN_PAD_EN
  assign emit = 1'b1;
`else
  assign emit = (row >= RW'(K-1)) && (col >= CW'(K-1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_out   <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (accept) begin
      // accept implies the output slot is free or draining this cycle.
      win_valid <= emit;
      win_last  <= emit & row_wrap & col_wrap;
      if (emit) begin
        win_out <= pack_window(win_d);
      end
    end else if (win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// ---------------------------------------------------------------------------
// tb_window_3x3_gen
// Emulates the line-buffer taps with p(r,c) = 0x100 + 16*r + c and checks
// every window against a reference computed directly from pixel coordinates.
// ---------------------------------------------------------------------------
module tb_window_3x3_gen;

  localparam int DW = 16;
  localparam int W  = 10;
  localparam int H  = 10;
  localparam int OW = 9*DW;

`ifdef WINDOW_GEN_PAD_EN
  localparam int EXP_WINS  = W*H;
  localparam int FIRST_ACC = 1;
`else
  localparam int EXP_WINS  = (W-2)*(H-2);
  localparam int FIRST_ACC = 2*W + 3;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [3*DW-1:0] tap_in;
  logic            tap_valid;
  logic            tap_ready;
  logic [OW-1:0]   win_out;
  logic            win_valid;
  logic            win_ready;
  logic            win_last;

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .tap_in    (tap_in),
    .tap_valid (tap_valid),
    .tap_ready (tap_ready),
    .win_out   (win_out),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_last  (win_last)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  logic [OW:0]   exp_q[$];       // {last, window}
  int            mr, mc;         // raster position of the next pixel
  int            acc_cnt;        // accepts since last reset/phase start
  int            win_cnt;        // windows consumed in the phase
  int            last_cnt;
  logic [DW-1:0] last_e8;
  logic          got_first;
  logic [OW-1:0] first_win;
  int            first_acc;

  task automatic check(input string tag, input logic [OW:0] got, input logic [OW:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(32'h100 + 16*r + c);
  endfunction

  function automatic logic [OW-1:0] ref_window(input int r, input int c);
    logic [OW-1:0] w;
    logic [DW-1:0] v;
    int rr, cc;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rr = r - 2 + i;
        cc = c - 2 + j;
        v  = pix(rr, cc);
`ifdef WINDOW_GEN_PAD_EN
        if (rr < 0 || cc < 0) v = '0;
`endif
        w[(3*i+j)*DW +: DW] = v;
      end
    end
    return w;
  endfunction

  function automatic bit ref_emits(input int r, input int c);
`ifdef WINDOW_GEN_PAD_EN
    return 1'b1;
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  task automatic phase_reset_stats();
    win_cnt   = 0;
    last_cnt  = 0;
    last_e8   = '0;
    got_first = 1'b0;
    first_win = '0;
    first_acc = -1;
  endtask

  // ---------------- driver + per-cycle checks ----------------
  task automatic step(input logic tv, input logic wr);
    logic acc, rdy;
    logic [OW:0] e;
    @(negedge clk);
    tap_valid = tv;
    win_ready = wr;
    tap_in    = {pix(mr-2, mc), pix(mr-1, mc), pix(mr, mc)};
    #1;
    rdy = rst && (exp_q.size() == 0 || wr);
    acc = rdy && tv;
    check("win_valid", win_valid, exp_q.size() != 0);
    check("tap_ready", tap_ready, rdy);
    if (exp_q.size() != 0) begin
      check("window", {win_last, win_out}, exp_q[0]);
      if (wr) begin
        e = exp_q.pop_front();
        win_cnt++;
        if (!got_first) begin
          got_first = 1'b1;
          first_win = win_out;
          first_acc = acc_cnt;
        end
        if (win_last) begin
          last_cnt++;
          last_e8 = win_out[8*DW +: DW];
        end
      end
    end
    if (acc) begin
      if (ref_emits(mr, mc))
        exp_q.push_back({(mr == H-1) && (mc == W-1), ref_window(mr, mc)});
      acc_cnt++;
      if (mc == W-1) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    tap_valid = 1'b0;
    rst       = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  int target;
  bit stalled;

  initial begin
    rst       = 1'b0;
    tap_valid = 1'b1;
    win_ready = 1'b1;
    tap_in    = '0;
    mr = 0; mc = 0; acc_cnt = 0;
    phase_reset_stats();

    // 1. reset held with tap_valid high
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 1'b1);
      check("rst_win_out", win_out, '0);
      check("rst_win_last", win_last, 1'b0);
    end
    release_reset();

    // 2. full frame at full throughput
    phase_reset_stats();
    acc_cnt = 0;
    for (int n = 0; n < W*H; n++) step(1'b1, 1'b1);
    drain();
    check("frame_a_accepts", acc_cnt, W*H);
    check("frame_a_windows", win_cnt, EXP_WINS);
    check("frame_a_last_cnt", last_cnt, 1);
    check("frame_a_last_e8", last_e8, 16'h199);
`ifdef WINDOW_GEN_PAD_EN
    check("frame_a_first", first_win, {16'h100, 128'h0});
`else
    check("frame_a_first_e0", first_win[0*DW +: DW], 16'h100);
    check("frame_a_first_e4", first_win[4*DW +: DW], 16'h111);
    check("frame_a_first_e8", first_win[8*DW +: DW], 16'h122);
`endif

    // 3/4. random handshakes plus one 5-cycle stall mid-row
    phase_reset_stats();
    acc_cnt = 0;
    target  = W*H;
    stalled = 0;
    for (int n = 0; n < 4000 && acc_cnt < target; n++) begin
      if (!stalled && mr == 4 && mc == 5) begin
        stalled = 1;
        step(1'b1, 1'b1);
        for (int s = 0; s < 5; s++) step(1'b1, 1'b0);
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end
    end
    drain();
    check("frame_b_accepts", acc_cnt, target);
    check("frame_b_windows", win_cnt, EXP_WINS);
    check("frame_b_last_cnt", last_cnt, 1);

    // 5. reset asserted while pixel (5,5) is presented
    for (int n = 0; n < 200 && !(mr == 5 && mc == 5); n++) step(1'b1, 1'b1);
    check("reached_5_5", (mr == 5) && (mc == 5), 1'b1);
    @(negedge clk);
    tap_valid = 1'b1;
    rst       = 1'b0;
    #1;
    check("midrst_win_valid", win_valid, 1'b0);
    check("midrst_win_out", win_out, '0);
    check("midrst_tap_ready", tap_ready, 1'b0);
    exp_q.delete();
    mr = 0; mc = 0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    release_reset();

    phase_reset_stats();
    acc_cnt = 0;
    for (int n = 0; n < W*H; n++) step(1'b1, 1'b1);
    drain();
    check("frame_c_windows", win_cnt, EXP_WINS);
    check("frame_c_first_acc", first_acc, FIRST_ACC);
`ifdef WINDOW_GEN_PAD_EN
    check("frame_c_first_e8", first_win[8*DW +: DW], 16'h100);
`else
    check("frame_c_first_e8", first_win[8*DW +: DW], 16'h122);
`endif
    check("frame_c_last_cnt", last_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
